// File: rtl/timer_avalon_pkg.sv
// Register map, control bits, FSM states and bus-cycle helpers for the interval-timer master.
// Snapshot states are present only when TIMER_SNAPSHOT_EN is defined.
package timer_avalon_pkg;

    localparam logic [2:0] ADDR_STATUS   = 3'd0;
    localparam logic [2:0] ADDR_CONTROL  = 3'd1;
    localparam logic [2:0] ADDR_PERIOD_L = 3'd2;
    localparam logic [2:0] ADDR_PERIOD_H = 3'd3;
    localparam logic [2:0] ADDR_SNAP_L   = 3'd4;
    localparam logic [2:0] ADDR_SNAP_H   = 3'd5;

    localparam int CTRL_ITO   = 0;
    localparam int CTRL_CONT  = 1;
    localparam int CTRL_START = 2;
    localparam int CTRL_STOP  = 3;

    typedef enum logic [3:0] {
        ST_IDLE     = 4'd0,
        ST_WR_PL    = 4'd1,
        ST_WR_PH    = 4'd2,
        ST_WR_CTRL  = 4'd3,
        ST_RUN      = 4'd4,
        ST_CLR_ST   = 4'd5,
        ST_STOP     = 4'd6
`ifdef TIMER_SNAPSHOT_EN
        ,
        ST_SNAP_WR  = 4'd7,
        ST_SNAP_RDL = 4'd8,
        ST_SNAP_RDH = 4'd9,
        ST_SNAP_CAP = 4'd10
`endif
    } state_t;

    typedef struct packed {
        logic        cs;
        logic        write_n;
        logic [2:0]  addr;
        logic [15:0] data;
    } bus_t;

    function automatic bus_t bus_idle();
        bus_t b;
        b.cs      = 1'b0;
        b.write_n = 1'b1;
        b.addr    = ADDR_STATUS;
        b.data    = 16'h0000;
        return b;
    endfunction

    function automatic bus_t bus_write(input logic [2:0] addr, input logic [15:0] data);
        bus_t b;
        b.cs      = 1'b1;
        b.write_n = 1'b0;
        b.addr    = addr;
        b.data    = data;
        return b;
    endfunction

`ifdef TIMER_SNAPSHOT_EN
    function automatic bus_t bus_read(input logic [2:0] addr);
        bus_t b;
        b.cs      = 1'b1;
        b.write_n = 1'b1;
        b.addr    = addr;
        b.data    = 16'h0000;
        return b;
    endfunction
`endif

    function automatic logic [15:0] ctrl_start_word(input logic cont);
        logic [15:0] w;
        w             = 16'h0000;
        w[CTRL_ITO]   = 1'b1;
        w[CTRL_CONT]  = cont;
        w[CTRL_START] = 1'b1;
        return w;
    endfunction

    function automatic logic [15:0] ctrl_stop_word();
        logic [15:0] w;
        w            = 16'h0000;
        w[CTRL_STOP] = 1'b1;
        return w;
    endfunction

endpackage

// File: rtl/timer_avalon_master_ctrl.sv
// Avalon-MM master that programs, runs and services the interval timer s1 port without a CPU.
// Optional TIMER_SNAPSHOT_EN adds a snapshot read of the running counter.
module timer_avalon_master_ctrl
    import timer_avalon_pkg::*;
#(
    parameter int          TICK_W     = 16,
    parameter logic [31:0] MIN_PERIOD = 32'd1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cmd_start,
    input  logic              cmd_stop,
    input  logic [31:0]       cmd_period,
    input  logic              cmd_continuous,
    output logic [2:0]        av_address,
    output logic              av_chipselect,
    output logic              av_write_n,
    output logic [15:0]       av_writedata,
    input  logic [15:0]       av_readdata,
    input  logic              timer_irq,
    output logic              busy,
    output logic              tick,
    output logic [TICK_W-1:0] tick_count,
    output logic              done,
    output logic              cmd_err
`ifdef TIMER_SNAPSHOT_EN
    ,
    input  logic              snap_req,
    output logic [31:0]       snap_value,
    output logic              snap_valid
`endif
);

    state_t      state;
    bus_t        bus;
    logic [31:0] period;
    logic        cont;
    logic        stop_pending;
    // The status clear lands one edge after CLR_ST, so the irq seen in the next cycle is stale.
    logic        irq_mask;
`ifdef TIMER_SNAPSHOT_EN
    logic [15:0] snap_lo;
`else
    logic        readdata_unused;
    assign readdata_unused = ^av_readdata;
`endif

    assign av_chipselect = bus.cs;
    assign av_write_n    = bus.write_n;
    assign av_address    = bus.addr;
    assign av_writedata  = bus.data;

    // Controller FSM; bus outputs are registered for the state being entered.
    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= ST_IDLE;
            bus          <= bus_idle();
            period       <= 32'h0000_0000;
            cont         <= 1'b0;
            stop_pending <= 1'b0;
            irq_mask     <= 1'b0;
            busy         <= 1'b0;
            tick         <= 1'b0;
            tick_count   <= '0;
            done         <= 1'b0;
            cmd_err      <= 1'b0;
`ifdef TIMER_SNAPSHOT_EN
            snap_lo      <= 16'h0000;
            snap_value   <= 32'h0000_0000;
            snap_valid   <= 1'b0;
`endif
        end else begin
            bus      <= bus_idle();
            tick     <= 1'b0;
            done     <= 1'b0;
            cmd_err  <= 1'b0;
            irq_mask <= 1'b0;
`ifdef TIMER_SNAPSHOT_EN
            snap_valid <= 1'b0;
`endif
            case (state)
                ST_IDLE: begin
                    if (cmd_start) begin
                        if (cmd_period >= MIN_PERIOD) begin
                            period       <= cmd_period;
                            cont         <= cmd_continuous;
                            tick_count   <= '0;
                            stop_pending <= 1'b0;
                            busy         <= 1'b1;
                            state        <= ST_WR_PL;
                            bus          <= bus_write(ADDR_PERIOD_L, cmd_period[15:0]);
                        end else begin
                            cmd_err <= 1'b1;
                        end
                    end
                end
                ST_WR_PL: begin
                    if (cmd_stop) stop_pending <= 1'b1;
                    state <= ST_WR_PH;
                    bus   <= bus_write(ADDR_PERIOD_H, period[31:16]);
                end
                ST_WR_PH: begin
                    if (cmd_stop) stop_pending <= 1'b1;
                    state <= ST_WR_CTRL;
                    bus   <= bus_write(ADDR_CONTROL, ctrl_start_word(cont));
                end
                ST_WR_CTRL: begin
                    if (cmd_stop) stop_pending <= 1'b1;
                    state <= ST_RUN;
                end
                ST_RUN: begin
                    if (timer_irq && !irq_mask) begin
                        if (cmd_stop) stop_pending <= 1'b1;
                        tick       <= 1'b1;
                        tick_count <= tick_count + TICK_W'(1);
                        state      <= ST_CLR_ST;
                        bus        <= bus_write(ADDR_STATUS, 16'h0000);
                    end else if (stop_pending || cmd_stop) begin
                        done  <= 1'b1;
                        state <= ST_STOP;
                        bus   <= bus_write(ADDR_CONTROL, ctrl_stop_word());
`ifdef TIMER_SNAPSHOT_EN
                    end else if (snap_req) begin
                        state <= ST_SNAP_WR;
                        bus   <= bus_write(ADDR_SNAP_L, 16'h0000);
`endif
                    end
                end
                ST_CLR_ST: begin
                    if (stop_pending || cmd_stop) begin
                        done  <= 1'b1;
                        state <= ST_STOP;
                        bus   <= bus_write(ADDR_CONTROL, ctrl_stop_word());
                    end else if (cont) begin
                        irq_mask <= 1'b1;
                        state    <= ST_RUN;
                    end else begin
                        done  <= 1'b1;
                        busy  <= 1'b0;
                        state <= ST_IDLE;
                    end
                end
                ST_STOP: begin
                    stop_pending <= 1'b0;
                    busy         <= 1'b0;
                    state        <= ST_IDLE;
                end
`ifdef TIMER_SNAPSHOT_EN
                // Readdata lags the read address by one cycle, hence the capture offsets.
                ST_SNAP_WR: begin
                    if (cmd_stop) stop_pending <= 1'b1;
                    state <= ST_SNAP_RDL;
                    bus   <= bus_read(ADDR_SNAP_L);
                end
                ST_SNAP_RDL: begin
                    if (cmd_stop) stop_pending <= 1'b1;
                    state <= ST_SNAP_RDH;
                    bus   <= bus_read(ADDR_SNAP_H);
                end
                ST_SNAP_RDH: begin
                    if (cmd_stop) stop_pending <= 1'b1;
                    snap_lo <= av_readdata;
                    state   <= ST_SNAP_CAP;
                end
                ST_SNAP_CAP: begin
                    if (cmd_stop) stop_pending <= 1'b1;
                    snap_value <= {av_readdata, snap_lo};
                    snap_valid <= 1'b1;
                    state      <= ST_RUN;
                end
`endif
                default: begin
                    busy  <= 1'b0;
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_timer_avalon_master_ctrl.sv
// Self-checking bench: a behavioural interval-timer slave drives irq/readdata, directed and
// random commands are checked against bus-transaction and tick expectations from that model.
module tb_timer_avalon_master_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        cmd_start;
    logic        cmd_stop;
    logic [31:0] cmd_period;
    logic        cmd_continuous;
    logic [2:0]  av_address;
    logic        av_chipselect;
    logic        av_write_n;
    logic [15:0] av_writedata;
    logic [15:0] av_readdata;
    logic        timer_irq;
    logic        busy;
    logic        tick;
    logic [15:0] tick_count;
    logic        done;
    logic        cmd_err;
`ifdef TIMER_SNAPSHOT_EN
    logic        snap_req;
    logic [31:0] snap_value;
    logic        snap_valid;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    timer_avalon_master_ctrl #(.TICK_W(16), .MIN_PERIOD(32'd1)) dut (
        .clk            (clk),
        .reset          (reset),
        .cmd_start      (cmd_start),
        .cmd_stop       (cmd_stop),
        .cmd_period     (cmd_period),
        .cmd_continuous (cmd_continuous),
        .av_address     (av_address),
        .av_chipselect  (av_chipselect),
        .av_write_n     (av_write_n),
        .av_writedata   (av_writedata),
        .av_readdata    (av_readdata),
        .timer_irq      (timer_irq),
        .busy           (busy),
        .tick           (tick),
        .tick_count     (tick_count),
        .done           (done),
        .cmd_err        (cmd_err)
`ifdef TIMER_SNAPSHOT_EN
        ,
        .snap_req       (snap_req),
        .snap_value     (snap_value),
        .snap_valid     (snap_valid)
`endif
    );

    // Behavioural interval timer: counts down the effective period, flags timeouts, irq one edge late.
    logic [31:0] m_period = 32'h0;
    logic [31:0] m_count  = 32'h0;
    logic [31:0] m_snap   = 32'h0;
    logic        m_run    = 1'b0;
    logic        m_cont   = 1'b0;
    logic        m_ito    = 1'b0;
    logic        m_to     = 1'b0;
    logic        m_irq    = 1'b0;
    logic [15:0] m_rdata  = 16'h0;
    int          m_timeouts = 0;
    int          ovr_period = 0;
    bit          snap_force = 1'b0;
    logic [31:0] eff_period;

    assign eff_period  = (ovr_period != 0) ? 32'(ovr_period) : m_period;
    assign timer_irq   = m_irq;
    assign av_readdata = m_rdata;

    always @(posedge clk) begin
        m_irq <= m_to & m_ito;
        if (av_chipselect && av_write_n)
            m_rdata <= (av_address == 3'd4) ? m_snap[15:0] :
                       (av_address == 3'd5) ? m_snap[31:16] : 16'h0;
        if (av_chipselect && !av_write_n) begin
            case (av_address)
                3'd0: m_to <= 1'b0;
                3'd1: begin
                    m_ito  <= av_writedata[0];
                    m_cont <= av_writedata[1];
                    if (av_writedata[3]) m_run <= 1'b0;
                    else if (av_writedata[2]) begin
                        m_run   <= 1'b1;
                        m_count <= eff_period - 32'd1;
                    end
                end
                3'd2: begin m_period[15:0]  <= av_writedata; m_run <= 1'b0; end
                3'd3: begin m_period[31:16] <= av_writedata; m_run <= 1'b0; end
                3'd4: m_snap <= snap_force ? 32'h0001_2345 : m_count;
                default: ;
            endcase
        end else if (m_run) begin
            if (m_count == 32'd0) begin
                m_to       <= 1'b1;
                m_timeouts <= m_timeouts + 1;
                if (m_cont) m_count <= eff_period - 32'd1;
                else        m_run   <= 1'b0;
            end else begin
                m_count <= m_count - 32'd1;
            end
        end
    end

    logic [20:0] bus_w;
    assign bus_w = {av_chipselect, av_write_n, av_address, av_writedata};

    function automatic logic [20:0] wr(input logic [2:0] a, input logic [15:0] d);
        return {1'b1, 1'b0, a, d};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    task automatic wait_tick(input string tag, input int base);
        int n;
        n = 0;
        step();
        while (tick !== 1'b1 && n < 500) begin
            step();
            n++;
        end
        check({tag, "_tick_seen"}, 32'(tick), 32'd1);
        if (tick === 1'b1) begin
            check({tag, "_status_clear"}, 32'(bus_w), 32'(wr(3'd0, 16'h0000)));
            check({tag, "_tick_count"}, 32'(tick_count), 32'(m_timeouts - base));
        end
    endtask

    task automatic run_cmd(input logic [31:0] period, input logic cont, input int ovr,
                           input int n_ticks, input bit stop_on_irq);
        int base;
        int n;
        ovr_period = ovr;
        base = m_timeouts;
        cmd_start = 1'b1; cmd_period = period; cmd_continuous = cont;
        step();
        cmd_start = 1'b0;
        check("wr_period_l", 32'(bus_w), 32'(wr(3'd2, period[15:0])));
        check("busy_after_start", 32'(busy), 32'd1);
        step();
        check("wr_period_h", 32'(bus_w), 32'(wr(3'd3, period[31:16])));
        step();
        check("wr_control", 32'(bus_w), 32'(wr(3'd1, cont ? 16'h0007 : 16'h0005)));
        step();
        check("run_bus_idle", 32'(av_chipselect), 32'd0);
        cmd_start = 1'b1; cmd_period = 32'd0;
        step();
        cmd_start = 1'b0;
        check("start_while_busy", 32'({cmd_err, av_chipselect, busy}), 32'd1);
        if (!cont) begin
            wait_tick("oneshot", base);
            step();
            check("oneshot_end", 32'({done, busy, av_chipselect}), 32'b100);
            check("oneshot_count", 32'(tick_count), 32'd1);
        end else begin
            for (int i = 0; i < n_ticks; i++) wait_tick("cont", base);
            check("cont_busy", 32'(busy), 32'd1);
            check("cont_count", 32'(tick_count), 32'(n_ticks));
            if (stop_on_irq) begin
                step();
                step();
                n = 0;
                while (timer_irq !== 1'b1 && n < 500) begin
                    step();
                    n++;
                end
                check("irq_rise_seen", 32'(timer_irq), 32'd1);
                cmd_stop = 1'b1;
                step();
                cmd_stop = 1'b0;
                check("prio_clear_first", 32'(bus_w), 32'(wr(3'd0, 16'h0000)));
                check("prio_tick", 32'(tick), 32'd1);
                check("prio_count", 32'(tick_count), 32'(n_ticks + 1));
            end else begin
                cmd_stop = 1'b1;
            end
            step();
            cmd_stop = 1'b0;
            check("stop_write", 32'(bus_w), 32'(wr(3'd1, 16'h0008)));
            check("stop_done_busy", 32'({done, busy}), 32'b11);
            step();
            check("stop_idle", 32'({done, busy, av_chipselect}), 32'b000);
            check("final_count_vs_model", 32'(tick_count), 32'(m_timeouts - base));
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] p;
        reset = 1'b1; cmd_start = 1'b0; cmd_stop = 1'b0; cmd_period = 32'd0; cmd_continuous = 1'b0;
`ifdef TIMER_SNAPSHOT_EN
        snap_req = 1'b0;
`endif
        step(); step(); step();
        check("reset_bus", 32'(bus_w), 32'(21'b0_1_000_0000000000000000));
        check("reset_flags", 32'({busy, tick, done, cmd_err}), 32'd0);
        check("reset_count", 32'(tick_count), 32'd0);
        reset = 1'b0;
        step();

        // Continuous 0x186A0, timer model shortened to 10; five ticks then irq+stop together.
        run_cmd(32'h0001_86A0, 1'b1, 10, 5, 1'b1);
        // One-shot period 20.
        run_cmd(32'd20, 1'b0, 0, 1, 1'b0);

        // Rejected period.
        cmd_start = 1'b1; cmd_period = 32'd0; cmd_continuous = 1'b1;
        step();
        cmd_start = 1'b0;
        check("reject_err", 32'({cmd_err, av_chipselect, busy}), 32'b100);
        step();
        check("reject_after", 32'({cmd_err, av_chipselect, busy}), 32'b000);

        // Stop requested during WR_PH is honoured after WR_CTRL and one RUN cycle.
        ovr_period = 1000;
        cmd_start = 1'b1; cmd_period = 32'h0000_4000; cmd_continuous = 1'b1;
        step();
        cmd_start = 1'b0;
        check("ph_stop_wr_pl", 32'(bus_w), 32'(wr(3'd2, 16'h4000)));
        step();
        check("ph_stop_wr_ph", 32'(bus_w), 32'(wr(3'd3, 16'h0000)));
        cmd_stop = 1'b1;
        step();
        cmd_stop = 1'b0;
        check("ph_stop_wr_ctrl", 32'(bus_w), 32'(wr(3'd1, 16'h0007)));
        step();
        check("ph_stop_run", 32'({av_chipselect, busy}), 32'b01);
        step();
        check("ph_stop_write", 32'(bus_w), 32'(wr(3'd1, 16'h0008)));
        check("ph_stop_done", 32'(done), 32'd1);
        step();
        check("ph_stop_idle", 32'({busy, done}), 32'b00);

        // Reset in the middle of WR_PH.
        cmd_start = 1'b1; cmd_period = 32'h0003_0040; cmd_continuous = 1'b0;
        step();
        cmd_start = 1'b0;
        step();
        check("rst_mid_wr_ph", 32'(bus_w), 32'(wr(3'd3, 16'h0003)));
        reset = 1'b1;
        step();
        check("rst_mid_bus", 32'(bus_w), 32'(21'b0_1_000_0000000000000000));
        check("rst_mid_flags", 32'({busy, tick, done, cmd_err}), 32'd0);
        check("rst_mid_count", 32'(tick_count), 32'd0);
        reset = 1'b0;
        step();
        check("rst_mid_after", 32'({av_chipselect, busy}), 32'b00);

        // Random periods/modes; model period kept short so timeouts come quickly.
        for (int k = 0; k < 6; k++) begin
            p = $urandom;
            if (p == 32'd0) p = 32'd1;
            run_cmd(p, 1'($urandom_range(0, 1)), int'($urandom_range(12, 40)),
                    int'($urandom_range(1, 4)), 1'b0);
        end

`ifdef TIMER_SNAPSHOT_EN
        snap_force = 1'b1;
        ovr_period = 1000;
        cmd_start = 1'b1; cmd_period = 32'h0001_2345; cmd_continuous = 1'b1;
        step();
        cmd_start = 1'b0;
        step(); step(); step();
        snap_req = 1'b1;
        step();
        snap_req = 1'b0;
        check("snap_wr", 32'(bus_w[20:16]), 32'({1'b1, 1'b0, 3'd4}));
        step();
        check("snap_rd_l", 32'(bus_w[20:16]), 32'({1'b1, 1'b1, 3'd4}));
        step();
        check("snap_rd_h", 32'(bus_w[20:16]), 32'({1'b1, 1'b1, 3'd5}));
        step();
        check("snap_cap_idle", 32'(av_chipselect), 32'd0);
        step();
        check("snap_valid", 32'(snap_valid), 32'd1);
        check("snap_value", snap_value, 32'h0001_2345);
        cmd_stop = 1'b1;
        step();
        cmd_stop = 1'b0;
        check("snap_stop", 32'(bus_w), 32'(wr(3'd1, 16'h0008)));
        step();
        check("snap_idle", 32'({busy, snap_valid}), 32'b00);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
